// File: rtl/lb_arbiter_pkg.sv
// lb_arbiter_pkg: shared types, defaults and round-robin pick for lb_arbiter
package lb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADDEAD;
  // Lone requester wins outright; on a tie the master that did not go last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic rr_last);
    return (req0 && req1) ? ~rr_last : req1;
  endfunction
endpackage

// File: rtl/lb_arbiter.sv
// lb_arbiter: round-robin two-master local-bus arbiter with ack watchdog
//   clk, rst (async, active-low)
//   m0_*/m1_* : master write/read requests in, wready/rvalid/rdata/err acks out
//   lb_*      : single slave port, requests out, wready/rvalid/rdata in
module lb_arbiter
  import lb_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wen,
  output logic              m0_wready,
  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic              m0_ren,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wen,
  output logic              m1_wready,
  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic              m1_ren,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);
  // Sized so the counter can hold TIMEOUT without wrapping.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  state_t state, state_nxt;
  logic owner, rr_last, req0, req1, win, win_wen;
  logic busy, tmo, slv_ack, done, err;
  logic [CW-1:0] tmo_cnt;
  logic [DATA_W-1:0] rdata;
  assign req0 = m0_wen | m0_ren;
  assign req1 = m1_wen | m1_ren;
  assign win = rr_pick(req0, req1, rr_last);
  assign win_wen = win ? m1_wen : m0_wen;
  assign busy = state != IDLE;
  assign tmo = busy && tmo_cnt == TMO_LAST;
  assign slv_ack = (state == WR && lb_wready) || (state == RD && lb_rvalid);
  // A slave ack in the final watchdog cycle wins, so err only fires without one.
  assign done = slv_ack || tmo;
  assign err = tmo && !slv_ack;
  assign rdata = lb_rvalid ? lb_rdata : ERR_DATA;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // Write beats read for the same master when both are raised.
  always_comb
    state_nxt = !busy ? ((req0 || req1) ? (win_wen ? WR : RD) : IDLE) : (done ? IDLE : state);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner <= 1'b0;
      rr_last <= 1'b1;
      tmo_cnt <= '0;
    end else if (!busy) begin
      if (req0 || req1) begin
        owner <= win;
        rr_last <= win;
      end
      tmo_cnt <= '0;
    end else tmo_cnt <= done ? '0 : tmo_cnt + CW'(1);
  always_comb begin
    lb_wen = state == WR;
    lb_ren = state == RD;
    lb_waddr = lb_wen ? (owner ? m1_waddr : m0_waddr) : '0;
    lb_wdata = lb_wen ? (owner ? m1_wdata : m0_wdata) : '0;
    lb_wstrb = lb_wen ? (owner ? m1_wstrb : m0_wstrb) : '0;
    lb_raddr = lb_ren ? (owner ? m1_raddr : m0_raddr) : '0;
    m0_wready = lb_wen && done && !owner;
    m1_wready = lb_wen && done && owner;
    m0_rvalid = lb_ren && done && !owner;
    m1_rvalid = lb_ren && done && owner;
    m0_rdata = m0_rvalid ? rdata : '0;
    m1_rdata = m1_rvalid ? rdata : '0;
    m0_err = err && !owner;
    m1_err = err && owner;
  end
endmodule

// File: tb/tb_lb_arbiter.sv
// tb_lb_arbiter: directed scoreboard bench for lb_arbiter
module tb_lb_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [31:0] ERRD = 32'hDEADDEAD;
  typedef struct {
    logic wr;
    logic rd;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [AW-1:0] raddr;
  } txn_t;
  typedef struct {
    logic rd;
    logic [DW-1:0] data;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0][AW-1:0] m_waddr, m_raddr;
  logic [1:0][DW-1:0] m_wdata, m_rdata;
  logic [1:0][SW-1:0] m_wstrb;
  logic [1:0] m_wen, m_ren, m_wready, m_rvalid, m_err;
  logic [AW-1:0] lb_waddr, lb_raddr;
  logic [DW-1:0] lb_wdata, lb_rdata;
  logic [SW-1:0] lb_wstrb;
  logic lb_wen, lb_ren, lb_wready, lb_rvalid;
  int swait = 0;
  int scnt = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  txn_t cur [2];
  logic [1:0] act = '0;
  logic [1:0] got_w = '0;
  logic [1:0] got_r = '0;
  txn_t mq [2][$];
  exp_t expq [2][$];
  int glog [$];
  int gcyc [$];

  lb_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_waddr(m_waddr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wen(m_wen[0]),
    .m0_wready(m_wready[0]), .m0_raddr(m_raddr[0]), .m0_ren(m_ren[0]),
    .m0_rdata(m_rdata[0]), .m0_rvalid(m_rvalid[0]), .m0_err(m_err[0]),
    .m1_waddr(m_waddr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wen(m_wen[1]),
    .m1_wready(m_wready[1]), .m1_raddr(m_raddr[1]), .m1_ren(m_ren[1]),
    .m1_rdata(m_rdata[1]), .m1_rvalid(m_rvalid[1]), .m1_err(m_err[1]),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
    .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] sdata(input logic [AW-1:0] a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Slave: acks after swait wait cycles; read data is a fixed function of address.
  assign lb_wready = lb_wen && scnt == swait;
  assign lb_rvalid = lb_ren && scnt == swait;
  assign lb_rdata = lb_ren ? sdata(lb_raddr) : '0;
  always @(posedge clk) scnt <= ((lb_wen || lb_ren) && !(lb_wready || lb_rvalid)) ? scnt + 1 : 0;

  function automatic logic outs_any();
    return |{lb_waddr, lb_wdata, lb_wstrb, lb_wen, lb_raddr, lb_ren, m_wready, m_rvalid, m_err, m_rdata};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int m, input logic wr, input logic rd, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [SW-1:0] ws, input logic [AW-1:0] ra,
                      input logic err);
    txn_t t;
    exp_t e;
    t.wr = wr;
    t.rd = rd;
    t.waddr = wa;
    t.wdata = wd;
    t.wstrb = ws;
    t.raddr = ra;
    if (wr) begin
      e.rd = 1'b0;
      e.data = '0;
      e.err = err;
      expq[m].push_back(e);
    end
    if (rd) begin
      e.rd = 1'b1;
      e.data = err ? ERRD : sdata(ra);
      e.err = err;
      expq[m].push_back(e);
    end
    mq[m].push_back(t);
  endtask

  // Master BFMs: hold each request until its ack, then move to the next queued one.
  always begin
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (act[m]) begin
        if (got_w[m]) cur[m].wr = 1'b0;
        if (got_r[m]) cur[m].rd = 1'b0;
        if (!cur[m].wr && !cur[m].rd) act[m] = 1'b0;
      end
      if (!act[m] && mq[m].size() > 0) begin
        cur[m] = mq[m].pop_front();
        act[m] = 1'b1;
      end
      m_wen[m] = act[m] && cur[m].wr;
      m_ren[m] = act[m] && cur[m].rd;
      m_waddr[m] = act[m] ? cur[m].waddr : '0;
      m_wdata[m] = act[m] ? cur[m].wdata : '0;
      m_wstrb[m] = act[m] ? cur[m].wstrb : '0;
      m_raddr[m] = act[m] ? cur[m].raddr : '0;
    end
  end

  task automatic check_ack(input int m);
    exp_t e;
    glog.push_back(m);
    gcyc.push_back(cyc);
    chk("ack_expected", 64'(expq[m].size() > 0), 64'(1));
    if (expq[m].size() > 0) begin
      e = expq[m].pop_front();
      chk("ack_kind", 64'({m_wready[m], m_rvalid[m]}), 64'({!e.rd, e.rd}));
      chk("ack_rdata", 64'(m_rdata[m]), 64'(e.rd ? e.data : 32'h0));
      chk("ack_err", 64'(m_err[m]), 64'(e.err));
      if (e.rd) chk("lb_raddr", 64'(lb_raddr), 64'(cur[m].raddr));
      else chk("lb_wfields", 64'({lb_waddr, lb_wstrb, lb_wdata}), 64'({cur[m].waddr, cur[m].wstrb, cur[m].wdata}));
    end
    chk("other_quiet", 64'({m_wready[1-m], m_rvalid[1-m], m_err[1-m], m_rdata[1-m]}), 64'(0));
  endtask

  always @(negedge clk) begin
    got_w <= m_wready;
    got_r <= m_rvalid;
    for (int m = 0; m < 2; m++)
      if (m_wready[m] || m_rvalid[m]) check_ack(m);
  end

  task automatic wait_idle();
    int n = 0;
    while ((act != 2'b00 || mq[0].size() != 0 || mq[1].size() != 0 ||
            expq[0].size() != 0 || expq[1].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 64'(n < 200), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    int n;
    @(negedge clk);
    chk("reset_outputs", 64'(outs_any()), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    // single m0 write, one-cycle arbitration latency
    push(0, 1'b1, 1'b0, 16'h0030, 32'hdeadbeef, 4'hf, 16'h0, 1'b0);
    @(negedge clk);
    chk("w1_idle_cycle_wen", 64'(lb_wen), 64'(0));
    @(negedge clk);
    chk("w1_lb_wen", 64'(lb_wen), 64'(1));
    chk("w1_lb_fields", 64'({lb_waddr, lb_wdata, lb_wstrb}), 64'({16'h0030, 32'hdeadbeef, 4'hf}));
    chk("w1_wready", 64'(m_wready), 64'(2'b01));
    wait_idle();
    // tie after reset: m0 first, then m1 read of 'h30
    do_reset();
    base = glog.size();
    push(0, 1'b1, 1'b0, 16'h0030, 32'h12345678, 4'h3, 16'h0, 1'b0);
    push(1, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h0030, 1'b0);
    wait_idle();
    chk("tie_grants", 64'(glog.size() - base), 64'(2));
    chk("tie_first_m0", 64'(glog[base]), 64'(0));
    chk("tie_second_m1", 64'(glog[base+1]), 64'(1));
    // continuous requests from both masters alternate with one idle cycle between
    base = glog.size();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b1, 1'b0, 16'(16'h0100 + 4 * i), 32'(32'hA0000000 + i), 4'(1 << i), 16'h0, 1'b0);
      push(1, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'(16'h0200 + 4 * i), 1'b0);
    end
    wait_idle();
    chk("alt_count", 64'(glog.size() - base), 64'(6));
    for (int i = 0; i < 6; i++)
      if (base + i < glog.size()) begin
        chk("alt_owner", 64'(glog[base+i]), 64'(i % 2));
        if (i > 0) chk("alt_gap", 64'(gcyc[base+i] - gcyc[base+i-1]), 64'(2));
      end
    // same master raises wen and ren: write then read
    base = glog.size();
    push(0, 1'b1, 1'b1, 16'h0040, 32'hcafef00d, 4'h5, 16'h0044, 1'b0);
    wait_idle();
    chk("wr_rd_count", 64'(glog.size() - base), 64'(2));
    chk("wr_rd_gap", 64'(gcyc[base+1] - gcyc[base]), 64'(2));
    chk("wr_rd_owner", 64'({glog[base][0], glog[base+1][0]}), 64'(0));
    // stalled slave: watchdog completes the read at RD cycle 8
    swait = 100;
    push(1, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h0050, 1'b1);
    n = 0;
    while (!lb_ren && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_rd_start", 64'(lb_ren), 64'(1));
    n = 1;
    while (!m_rvalid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_ack_cycle", 64'(n), 64'(8));
    chk("tmo_rdata", 64'(m_rdata[1]), 64'(ERRD));
    chk("tmo_err", 64'(m_err[1]), 64'(1));
    @(negedge clk);
    chk("tmo_ren_drop", 64'(lb_ren), 64'(0));
    wait_idle();
    // slave ack in the last watchdog cycle wins
    swait = 7;
    push(1, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h0054, 1'b0);
    n = 0;
    while (!lb_ren && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (!m_rvalid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("late_ack_cycle", 64'(n), 64'(8));
    chk("late_ack_noerr", 64'(m_err[1]), 64'(0));
    chk("late_ack_rdata", 64'(m_rdata[1]), 64'(sdata(16'h0054)));
    wait_idle();
    // asynchronous reset during a stalled write, then m0 wins the tie
    swait = 100;
    base = glog.size();
    push(1, 1'b1, 1'b0, 16'h0060, 32'h11223344, 4'hf, 16'h0, 1'b0);
    n = 0;
    while (!lb_wen && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wr_start", 64'(lb_wen), 64'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'(outs_any()), 64'(0));
    push(0, 1'b1, 1'b0, 16'h0064, 32'h55667788, 4'h3, 16'h0, 1'b0);
    swait = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_outs", 64'(outs_any()), 64'(0));
    rst = 1'b1;
    wait_idle();
    chk("rst_grants", 64'(glog.size() - base), 64'(2));
    chk("rst_tie_m0", 64'(glog[base]), 64'(0));
    chk("rst_tie_m1", 64'(glog[base+1]), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
